// File: rtl/layer_link_bist_if.sv
// Control, status and serial-line bundle for one layer_link_bist instance.
// The inject input exists only when BIST_ERR_INJECT_EN is defined.
interface layer_link_bist_if #(
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 16
);
  logic                 start;
  logic                 f_layer;
  logic                 data_in;
  logic                 data_out;
  logic [DATA_W-1:0]    rx_word;
  logic                 rx_valid;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic [ERR_CNT_W-1:0] err_cnt;
`ifdef BIST_ERR_INJECT_EN
  logic                 inject;

  modport master (
    output start, f_layer, data_in, inject,
    input  data_out, rx_word, rx_valid, busy, done, pass, timeout, err_cnt
  );
  modport slave (
    input  start, f_layer, data_in, inject,
    output data_out, rx_word, rx_valid, busy, done, pass, timeout, err_cnt
  );
`else
  modport master (
    output start, f_layer, data_in,
    input  data_out, rx_word, rx_valid, busy, done, pass, timeout, err_cnt
  );
  modport slave (
    input  start, f_layer, data_in,
    output data_out, rx_word, rx_valid, busy, done, pass, timeout, err_cnt
  );
`endif
endinterface

// File: rtl/layer_link_bist.sv
// Inter-layer serial link BIST: PRBS frame generator (f_layer=1) or checker/relay (f_layer=0).
// Optional per-word LSB error injection on the generator when BIST_ERR_INJECT_EN is defined.
module layer_link_bist #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_WORDS = 256,
  parameter int          ERR_CNT_W = 16,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst_n,
  layer_link_bist_if.slave bus
);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WORD_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [31:0]       SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 role_gen_reg;
  logic [31:0]          lfsr_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [WORD_W-1:0]    word_cnt_reg;
  logic [TMO_W-1:0]     tmo_cnt_reg;
  logic                 tail_reg;
  logic [DATA_W-1:0]    rx_shift_reg;
  logic [DATA_W-1:0]    exp_shift_reg;
  logic [DATA_W-1:0]    rx_word_reg;
  logic                 rx_valid_reg;
  logic                 data_out_reg;
  logic                 timeout_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic                 accept;
  logic                 lfsr_bit;
  logic [31:0]          lfsr_adv;
  logic                 step;
  logic                 word_end;
  logic                 last_bit;
  logic                 tx_bit;
  logic [DATA_W-1:0]    rx_next;
  logic [DATA_W-1:0]    exp_next;

  assign accept   = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign lfsr_bit = lfsr_reg[31];
  // x^32 + x^22 + x^2 + x + 1, Fibonacci form, shifting towards the MSB
  assign lfsr_adv = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
  // tail_reg marks the one extra RUN cycle after the last payload bit
  assign step     = (state_reg == RUN) && !tail_reg;
  assign word_end = (bit_cnt_reg == BIT_LAST);
  assign last_bit = word_end && (word_cnt_reg == WORD_LAST);
  assign rx_next  = (rx_shift_reg << 1) | DATA_W'(bus.data_in);
  assign exp_next = (exp_shift_reg << 1) | DATA_W'(lfsr_bit);

`ifdef BIST_ERR_INJECT_EN
  logic inj_word_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_word_reg <= 1'b0;
    end else if (accept) begin
      inj_word_reg <= 1'b0;
    end else if (step && role_gen_reg && (bit_cnt_reg == '0)) begin
      inj_word_reg <= bus.inject;
    end
  end

  // Only the line is corrupted; the LFSR sequence itself is untouched
  assign tx_bit = lfsr_bit ^ (word_end & inj_word_reg);
`else
  assign tx_bit = lfsr_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = bus.f_layer ? RUN : SYNC;
        end
      end
      SYNC: begin
        if (bus.data_in) begin
          state_next = RUN;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = DONE;
        end
      end
      RUN: begin
        if (tail_reg) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      role_gen_reg  <= 1'b0;
      lfsr_reg      <= SEED_EFF;
      bit_cnt_reg   <= '0;
      word_cnt_reg  <= '0;
      tmo_cnt_reg   <= '0;
      tail_reg      <= 1'b0;
      rx_shift_reg  <= '0;
      exp_shift_reg <= '0;
      rx_word_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      data_out_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (accept) begin
        role_gen_reg  <= bus.f_layer;
        lfsr_reg      <= SEED_EFF;
        bit_cnt_reg   <= '0;
        word_cnt_reg  <= '0;
        tmo_cnt_reg   <= '0;
        tail_reg      <= 1'b0;
        rx_shift_reg  <= '0;
        exp_shift_reg <= '0;
        timeout_reg   <= 1'b0;
        err_cnt_reg   <= '0;
        // A generator puts its start bit on the line in the first RUN cycle
        data_out_reg  <= bus.f_layer ? 1'b1 : bus.data_in;
      end else begin
        // Checker role relays the line in every state; generator idles low
        data_out_reg <= role_gen_reg ? 1'b0 : bus.data_in;

        if ((state_reg == SYNC) && !bus.data_in) begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          if (tmo_cnt_reg == TMO_LAST) begin
            timeout_reg <= 1'b1;
          end
        end

        if (step) begin
          lfsr_reg    <= lfsr_adv;
          bit_cnt_reg <= word_end ? '0 : bit_cnt_reg + 1'b1;
          if (word_end) begin
            word_cnt_reg <= word_cnt_reg + 1'b1;
          end
          if (last_bit) begin
            tail_reg <= 1'b1;
          end

          if (role_gen_reg) begin
            data_out_reg <= tx_bit;
          end else begin
            rx_shift_reg  <= rx_next;
            exp_shift_reg <= exp_next;
            if (word_end) begin
              rx_word_reg  <= rx_next;
              rx_valid_reg <= 1'b1;
              if ((rx_next != exp_next) && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.rx_word  = rx_word_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.busy     = (state_reg == SYNC) || (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.timeout  = timeout_reg;
  assign bus.err_cnt  = err_cnt_reg;
  assign bus.pass     = (state_reg == DONE) && (err_cnt_reg == '0) && !timeout_reg;

endmodule
